// File: rtl/pc_sequencer.sv
// Program counter and fetch/decode/execute/increment phase sequencer.
// The PC is written by jump targets in EXECUTE or advanced in INCREMENT, both gated by the jump logic's enable.
module pc_sequencer #(
    parameter int unsigned     WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clock,
    input  logic             input_clear,
    input  logic             input_mem_ready,
    input  logic [WIDTH-1:0] input_mem_data,
    input  logic             input_en_pc,
    input  logic [WIDTH-1:0] input_jump_addr,
    input  logic             input_halt,
    output logic [WIDTH-1:0] output_pc,
    output logic [WIDTH-1:0] output_instr,
    output logic             output_fetch,
    output logic             output_decode,
    output logic             output_execute,
    output logic             output_increment,
    output logic             output_halted
);

    // One-hot encoding so every phase strobe is a flop bit of the state register.
    typedef enum logic [4:0] {
        ST_FETCH     = 5'b00001,
        ST_DECODE    = 5'b00010,
        ST_EXECUTE   = 5'b00100,
        ST_INCREMENT = 5'b01000,
        ST_HALT      = 5'b10000
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;

    always_ff @(posedge clock) begin
        if (input_clear) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (input_mem_ready) begin
                        r_instr <= input_mem_data;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    // Halt wins over a jump; a taken jump skips INCREMENT.
                    if (input_halt) begin
                        r_state <= ST_HALT;
                    end else if (input_en_pc) begin
                        r_pc    <= input_jump_addr;
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_INCREMENT;
                    end
                end
                ST_INCREMENT: begin
                    if (input_en_pc) begin
                        r_pc <= r_pc + WIDTH'(1);
                    end
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign output_pc        = r_pc;
    assign output_instr     = r_instr;
    assign output_fetch     = r_state[0];
    assign output_decode    = r_state[1];
    assign output_execute   = r_state[2];
    assign output_increment = r_state[3];
    assign output_halted    = r_state[4];

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a reference model pushes expected snapshots per cycle,
// each scenario task pops and compares them, plus fixed-value checks from the scenario itself.
module tb_pc_sequencer;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         input_clear;
    logic         input_mem_ready;
    logic [W-1:0] input_mem_data;
    logic         input_en_pc;
    logic [W-1:0] input_jump_addr;
    logic         input_halt;
    logic [W-1:0] output_pc;
    logic [W-1:0] output_instr;
    logic         output_fetch;
    logic         output_decode;
    logic         output_execute;
    logic         output_increment;
    logic         output_halted;

    pc_sequencer #(.WIDTH(W), .RESET_VECTOR(8'h00)) dut (
        .clock            (clock),
        .input_clear      (input_clear),
        .input_mem_ready  (input_mem_ready),
        .input_mem_data   (input_mem_data),
        .input_en_pc      (input_en_pc),
        .input_jump_addr  (input_jump_addr),
        .input_halt       (input_halt),
        .output_pc        (output_pc),
        .output_instr     (output_instr),
        .output_fetch     (output_fetch),
        .output_decode    (output_decode),
        .output_execute   (output_execute),
        .output_increment (output_increment),
        .output_halted    (output_halted)
    );

    always #5 clock = ~clock;

    // ph = {halted, increment, execute, decode, fetch}
    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
        logic [4:0] ph;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 INCREMENT, 4 HALT
    int         m_st = 0;
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_instr = 8'h00;

    task automatic idle_inputs();
        input_clear     = 1'b0;
        input_mem_ready = 1'b0;
        input_mem_data  = 8'h00;
        input_en_pc     = 1'b0;
        input_jump_addr = 8'h00;
        input_halt      = 1'b0;
    endtask

    // Advance the model on the current inputs, push its prediction, clock the DUT, capture it.
    task automatic tick();
        snap_t e;
        snap_t o;
        if (input_clear) begin
            m_st = 0; m_pc = 8'h00; m_instr = 8'h00;
        end else begin
            case (m_st)
                0: if (input_mem_ready) begin m_instr = input_mem_data; m_st = 1; end
                1: m_st = 2;
                2: begin
                    if (input_halt) m_st = 4;
                    else if (input_en_pc) begin m_pc = input_jump_addr; m_st = 0; end
                    else m_st = 3;
                end
                3: begin
                    if (input_en_pc) m_pc = m_pc + 8'd1;
                    m_st = 0;
                end
                default: m_st = 4;
            endcase
        end
        e.pc = m_pc; e.instr = m_instr; e.ph = 5'(1 << m_st);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        o.pc = output_pc; o.instr = output_instr;
        o.ph = {output_halted, output_increment, output_execute, output_decode, output_fetch};
        obs_q.push_back(o);
    endtask

    // One instruction; noise drives en_pc high in FETCH/DECODE where it must be ignored.
    task automatic run_instr(input logic [7:0] data, input int stalls, input logic jump,
                             input logic [7:0] jaddr, input logic inc, input logic halt,
                             input logic noise);
        for (int i = 0; i < stalls; i++) begin
            input_mem_ready = 1'b0; input_mem_data = 8'($urandom); input_en_pc = noise;
            input_jump_addr = 8'($urandom);
            tick();
        end
        input_mem_ready = 1'b1; input_mem_data = data; input_en_pc = noise;
        tick();
        input_mem_ready = 1'b0; input_mem_data = 8'($urandom);
        tick();
        input_en_pc = jump; input_halt = halt; input_jump_addr = jaddr;
        tick();
        if (!jump && !halt) begin
            input_en_pc = inc; input_halt = 1'b0;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        input_clear = 1'b1; input_en_pc = 1'b1; input_mem_ready = 1'b1; input_mem_data = 8'h99;
        tick();
        idle_inputs();
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
        total++;
        if ({output_pc, output_instr, output_fetch, output_decode, output_execute,
             output_increment, output_halted} !== {8'h00, 8'h00, 5'b10000}) begin
            bad++;
            $display("FAIL reset_const: got pc=%h instr=%h f/d/e/i/h=%b%b%b%b%b want 00 00 10000",
                     output_pc, output_instr, output_fetch, output_decode, output_execute,
                     output_increment, output_halted);
        end
    endtask

    task automatic test_straight_line();
        run_instr(8'h11, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL straight_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
        total++;
        if (output_pc !== 8'h01 || output_instr !== 8'h11 || output_fetch !== 1'b1) begin
            bad++;
            $display("FAIL straight_const: got pc=%h instr=%h fetch=%b want 01 11 1",
                     output_pc, output_instr, output_fetch);
        end
    endtask

    task automatic test_jump();
        run_instr(8'h20, 0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
        run_instr(8'h21, 0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
        total++;
        if (output_pc !== 8'hA0 || output_fetch !== 1'b1 || output_increment !== 1'b0) begin
            bad++;
            $display("FAIL jump_target: got pc=%h fetch=%b inc=%b want a0 1 0",
                     output_pc, output_fetch, output_increment);
        end
        run_instr(8'h22, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL jump_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
        total++;
        if (output_pc !== 8'hA1) begin
            bad++;
            $display("FAIL jump_next: got pc=%h want a1", output_pc);
        end
    endtask

    task automatic test_stall();
        int fetch_cycles;
        logic [7:0] pc_before;
        pc_before = output_pc;
        run_instr(8'h3C, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        fetch_cycles = 1;  // fetch was already high entering the instruction
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].ph[0] !== 1'b1) break;
            fetch_cycles++;
        end
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
        total++;
        if (fetch_cycles !== 4 || output_instr !== 8'h3C || output_pc !== pc_before + 8'd1) begin
            bad++;
            $display("FAIL stall_const: got fetch_cycles=%0d instr=%h pc=%h want 4 3c %h",
                     fetch_cycles, output_instr, output_pc, pc_before + 8'd1);
        end
    endtask

    task automatic test_wrap_halt();
        run_instr(8'h40, 0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_instr(8'h41, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++;
        if (output_pc !== 8'h00) begin
            bad++;
            $display("FAIL wrap: got pc=%h want 00", output_pc);
        end
        run_instr(8'h42, 0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            input_mem_ready = 1'($urandom); input_mem_data = 8'($urandom);
            input_en_pc = 1'b1; input_jump_addr = 8'($urandom); input_halt = 1'($urandom);
            tick();
        end
        idle_inputs();
        total++;
        if (output_halted !== 1'b1 || output_pc !== 8'h00 || output_instr !== 8'h42 ||
            output_fetch !== 1'b0) begin
            bad++;
            $display("FAIL halt_hold: got halted=%b pc=%h instr=%h fetch=%b want 1 00 42 0",
                     output_halted, output_pc, output_instr, output_fetch);
        end
        input_clear = 1'b1;
        tick();
        idle_inputs();
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL wrap_halt_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
        total++;
        if (output_fetch !== 1'b1 || output_halted !== 1'b0 || output_pc !== 8'h00) begin
            bad++;
            $display("FAIL halt_clear: got fetch=%b halted=%b pc=%h want 1 0 00",
                     output_fetch, output_halted, output_pc);
        end
    endtask

    task automatic test_clear_exec();
        run_instr(8'h50, 0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        input_mem_ready = 1'b1; input_mem_data = 8'h51;
        tick();
        input_mem_ready = 1'b0;
        tick();
        input_clear = 1'b1; input_en_pc = 1'b1; input_jump_addr = 8'h40;
        tick();
        idle_inputs();
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL clear_exec_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
        total++;
        if (output_pc !== 8'h00 || output_fetch !== 1'b1 || output_execute !== 1'b0 ||
            output_instr !== 8'h00) begin
            bad++;
            $display("FAIL clear_exec: got pc=%h fetch=%b exec=%b instr=%h want 00 1 0 00",
                     output_pc, output_fetch, output_execute, output_instr);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            run_instr(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 8'($urandom),
                      1'($urandom), 1'b0, 1'($urandom));
        end
        while (exp_q.size() > 0) begin
            snap_t e; snap_t o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL b2b_sb: got pc=%h instr=%h ph=%b want pc=%h instr=%h ph=%b",
                         o.pc, o.instr, o.ph, e.pc, e.instr, e.ph);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_straight_line();
        test_jump();
        test_stall();
        test_wrap_halt();
        test_clear_exec();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Upstream/downstream partner of the jump-decision logic in the Decoder. It owns the program counter and the fetch/decode/execute/increment phase sequencer.
- Drives the `increment`/`execute` phase strobes into the jump logic and consumes the jump logic's `output_en_pc` as its PC write enable.
- Latches the fetched instruction byte and stops in a halt state on a HALT instruction.

Parameters:
- WIDTH, 8, width of PC, address bus and instruction register
- RESET_VECTOR, 0, PC value loaded on clear

Ports:
- clock  input  1  system clock; all state changes on rising edge
- input_clear  input  1  synchronous active-high reset
- input_mem_ready  input  1  memory has valid data on input_mem_data this cycle
- input_mem_data  input  WIDTH  instruction byte from program memory
- input_en_pc  input  1  PC write enable from jump logic
- input_jump_addr  input  WIDTH  jump target, sampled when a jump is taken
- input_halt  input  1  decoded HALT instruction, sampled in EXECUTE
- output_pc  output  WIDTH  current program counter / fetch address
- output_instr  output  WIDTH  instruction register
- output_fetch  output  1  high in FETCH state
- output_decode  output  1  high in DECODE state
- output_execute  output  1  high in EXECUTE state (feeds jump logic execute)
- output_increment  output  1  high in INCREMENT state (feeds jump logic increment)
- output_halted  output  1  high in HALT state

Behaviour:
- Reset: synchronous. When input_clear=1 at a rising edge, the following take effect after that edge, overriding all other inputs:
  - state=FETCH, output_pc=RESET_VECTOR, output_instr=0
  - output_fetch=1; decode/execute/increment/halted=0
- Clear mid-operation in any state, HALT included, has the same effect.
- States: FETCH, DECODE, EXECUTE, INCREMENT, HALT. Encoding is free. Phase outputs are Moore outputs decoded from state, and exactly one is high at a time.
- FETCH:
  - mem_ready=0: stay in FETCH, PC and instr hold.
  - mem_ready=1: output_instr<=input_mem_data, next state DECODE.
- DECODE: unconditional -> EXECUTE after 1 cycle.
- EXECUTE (priority order):
  - halt=1: next state HALT, PC holds. halt takes priority over en_pc.
  - else en_pc=1 (jump taken): output_pc<=input_jump_addr, next state FETCH. INCREMENT is skipped, so the target is not incremented.
  - else: PC holds, next state INCREMENT.
- INCREMENT:
  - en_pc=1: output_pc<=output_pc+1, modulo 2^WIDTH (0xFF wraps to 0x00 at WIDTH=8).
  - en_pc=0: PC holds.
  - Either case: next state FETCH.
- HALT: all strobes except output_halted low. PC/instr hold; all inputs except clear are ignored. Exit is by clear only.
- input_en_pc is ignored in FETCH, DECODE and HALT.
- Latency:
  - Non-jump instruction: 4 cycles (FETCH with ready=1, DECODE, EXECUTE, INCREMENT).
  - Taken jump: 3 cycles.
  - Each mem_ready=0 cycle in FETCH adds 1.
- output_pc and output_instr are registered; no combinational path from any input to any output.

Test Plan:
- Reset: clear=1 for 1 edge with RESET_VECTOR=0 -> pc=0x00, instr=0x00, fetch=1, all other strobes 0.
- Straight-line: ready=1, data=0x11, en_pc=1 only in INCREMENT -> pc=0x01 after 4 cycles. Strobe order fetch/decode/execute/increment, then fetch again.
- Taken jump: pc=0x05, en_pc=1 in EXECUTE, jump_addr=0xA0 -> pc=0xA0 at the next FETCH, no INCREMENT strobe. Next non-jump instruction gives pc=0xA1.
- Memory stall: ready=0 for 3 cycles in FETCH, then ready=1 with data=0x3C -> fetch stays high 4 cycles, instr=0x3C, pc unchanged until INCREMENT.
- Wrap and halt:
  - pc=0xFF plus an increment -> pc=0x00.
  - Next instruction: halt=1 and en_pc=1 in EXECUTE -> halted=1, pc=0x00 held for 10 cycles despite input activity.
  - clear=1 -> FETCH, pc=0x00.
- Clear mid-EXECUTE: clear=1 while en_pc=1 and jump_addr=0x40 -> pc=RESET_VECTOR (0x00), not 0x40, and state=FETCH.
